sha1_core: RTL

- Compression engine directly downstream of the Wishbone SHA1 front end.
- Consumes the 512-bit message block and start/soft-reset controls the front end latches.
- Runs the 80 SHA-1 rounds at one round per clock.
- Returns the 160-bit digest, a done flag, a panic flag and the current round index for the front end's status register and digest reads.

---
 rtl/sha1_pkg.sv | 38 +++
 rtl/sha1_core_if.sv | 40 ++++
 rtl/sha1_round.sv | 40 ++++
 rtl/sha1_core.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// sha1_pkg: shared types, constants and helpers for the SHA-1 compression core.
//   state_t   : core FSM states (IDLE, LOAD, ROUND, FINAL, DONE)
//   H_INIT    : SHA-1 initial chaining values H0..H4
//   K         : per-20-round additive constants
//   rotl      : 32-bit rotate left
//   f         : round logic function selected by round index
package sha1_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ROUND = 3'd2,
      FINAL = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [31:0] H_INIT [0:4] = '{
      32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
   };

   localparam logic [31:0] K [0:3] = '{
      32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hCA62C1D6
   };

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Ch for rounds 0-19, Maj for 40-59, Parity otherwise.
   function automatic logic [31:0] f(input logic [6:0] t, input logic [31:0] b,
                                     input logic [31:0] c, input logic [31:0] d);
      if (t < 7'd20)      return (b & c) | (~b & d);
      else if (t < 7'd40) return b ^ c ^ d;
      else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
      else                return b ^ c ^ d;
   endfunction

endpackage

// File: rtl/sha1_core_if.sv
// sha1_core_if: control/data bundle between the Wishbone front end (master)
// and the compression core (slave).
//   start_i    : level from the front end; a rising edge launches one block
//   soft_rst_i : synchronous soft reset
//   message_i  : 512-bit block, W0 in [31:0] ... W15 in [511:480]
//   digest_o   : H0 in [159:128] ... H4 in [31:0]
//   done_o, panic_o : sticky status flags
//   busy_o     : core is in LOAD, ROUND or FINAL
//   loop_idx_o : current round index while in ROUND, else 0
//   state_dbg  : core FSM state, for observation only
// Handshake: there is no ready signal. The master may raise start_i at any
// time; the core acts only on a 0->1 transition seen while idle or done, and
// a transition seen while busy_o is high is dropped and flagged on panic_o.
// message_i must stay stable from the launch until busy_o has been high for
// one cycle (the block is copied in LOAD). done_o stays high until the next
// accepted launch or a soft reset.
interface sha1_core_if;
   import sha1_pkg::*;

   logic         start_i;
   logic         soft_rst_i;
   logic [511:0] message_i;
   logic [159:0] digest_o;
   logic         done_o;
   logic         panic_o;
   logic         busy_o;
   logic [6:0]   loop_idx_o;
   state_t       state_dbg;

   modport master (
      output start_i, soft_rst_i, message_i,
      input  digest_o, done_o, panic_o, busy_o, loop_idx_o, state_dbg
   );

   modport slave (
      input  start_i, soft_rst_i, message_i,
      output digest_o, done_o, panic_o, busy_o, loop_idx_o, state_dbg
   );

endinterface

// File: rtl/sha1_round.sv
// sha1_round: combinational single SHA-1 round.
//   a..e            : working variables entering the round
//   w               : schedule word Wt for this round
//   t               : round index 0..79 (selects f and K)
//   a_next..e_next  : working variables after the round
module sha1_round
   import sha1_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   input  logic [31:0] e,
   input  logic [31:0] w,
   input  logic [6:0]  t,
   output logic [31:0] a_next,
   output logic [31:0] b_next,
   output logic [31:0] c_next,
   output logic [31:0] d_next,
   output logic [31:0] e_next
);

   logic [1:0] k_sel;

   always_comb begin
      k_sel = 2'd3;
      if (t < 7'd20)      k_sel = 2'd0;
      else if (t < 7'd40) k_sel = 2'd1;
      else if (t < 7'd60) k_sel = 2'd2;
   end

   always_comb begin
      a_next = rotl(a, 5) + f(t, b, c, d) + e + K[k_sel] + w;
      b_next = a;
      c_next = rotl(b, 30);
      d_next = c;
      e_next = d;
   end

endmodule

// File: rtl/sha1_core.sv
// sha1_core: SHA-1 compression engine, one round per clock.
//   wb_clk_i : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : sha1_core_if slave modport (controls, block, digest, status)
// Parameter ROUNDS (16..80, default 80) shortens the round loop for benches.
// Build option SHA1_CHAIN_EN: when defined, H0..H4 accumulate across blocks
// so consecutive launches hash a multi-block message; when undefined every
// block starts from the initial constants and no chaining state is kept.
module sha1_core
   import sha1_pkg::*;
#(
   parameter int ROUNDS = 80
)(
   input  logic        wb_clk_i,
   input  logic        reset_n,
   sha1_core_if.slave  bus
);

   state_t       state, state_n;
   logic         start_q;
   logic         launch;
   logic         busy;
   logic         last_round;
   logic [6:0]   t;
   logic [31:0]  a, b, c, d, e;
   logic [31:0]  a_nx, b_nx, c_nx, d_nx, e_nx;
   logic [31:0]  h     [0:4];
   logic [31:0]  h_sum [0:4];
   logic [31:0]  w_buf [0:15];
   logic [31:0]  wt;
   logic [3:0]   i0, i3, i8, i14;
   logic         done_q, panic_q;
   logic [159:0] digest_q;

   assign launch     = bus.start_i & ~start_q;
   assign last_round = (t == 7'(ROUNDS - 1));

   // Circular schedule: slot t[3:0] holds W(t-16), overwritten with Wt.
   always_comb begin
      i0  = t[3:0];
      i3  = i0 - 4'd3;
      i8  = i0 - 4'd8;
      i14 = i0 - 4'd14;
      if (t < 7'd16) wt = w_buf[i0];
      else           wt = rotl(w_buf[i3] ^ w_buf[i8] ^ w_buf[i14] ^ w_buf[i0], 1);
   end

   always_comb begin
      h_sum[0] = h[0] + a;
      h_sum[1] = h[1] + b;
      h_sum[2] = h[2] + c;
      h_sum[3] = h[3] + d;
      h_sum[4] = h[4] + e;
   end

   sha1_round u_round (
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d),
      .e      (e),
      .w      (wt),
      .t      (t),
      .a_next (a_nx),
      .b_next (b_nx),
      .c_next (c_nx),
      .d_next (d_nx),
      .e_next (e_nx)
   );

   // FSM state register
   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   // FSM next state; soft reset overrides everything, including a launch
   always_comb begin
      state_n = state;
      if (bus.soft_rst_i) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (launch) state_n = LOAD;
            LOAD:       state_n = ROUND;
            ROUND:      if (last_round) state_n = FINAL;
            FINAL:      state_n = DONE;
            default:    state_n = IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      busy            = (state == LOAD) || (state == ROUND) || (state == FINAL);
      bus.busy_o      = busy;
      bus.loop_idx_o  = (state == ROUND) ? t : 7'd0;
      bus.state_dbg   = state;
   end

   // Datapath and sticky status
   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         panic_q  <= 1'b0;
         digest_q <= '0;
         t        <= '0;
         a        <= '0;
         b        <= '0;
         c        <= '0;
         d        <= '0;
         e        <= '0;
         for (int i = 0; i < 5; i++)  h[i]     <= H_INIT[i];
         for (int i = 0; i < 16; i++) w_buf[i] <= '0;
      end else begin
         start_q <= bus.start_i;
         if (bus.soft_rst_i) begin
            done_q   <= 1'b0;
            panic_q  <= 1'b0;
            digest_q <= '0;
            t        <= '0;
            for (int i = 0; i < 5; i++) h[i] <= H_INIT[i];
         end else begin
            if (launch) begin
               if (busy) panic_q <= 1'b1;
               else      done_q  <= 1'b0;
            end
            case (state)
               LOAD: begin
                  for (int i = 0; i < 16; i++) w_buf[i] <= bus.message_i[32*i +: 32];
                  a <= h[0];
                  b <= h[1];
                  c <= h[2];
                  d <= h[3];
                  e <= h[4];
                  t <= '0;
               end
               ROUND: begin
                  a        <= a_nx;
                  b        <= b_nx;
                  c        <= c_nx;
                  d        <= d_nx;
                  e        <= e_nx;
                  w_buf[i0] <= wt;
                  t        <= last_round ? 7'd0 : t + 7'd1;
               end
               FINAL: begin
                  digest_q <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4]};
                  done_q   <= 1'b1;
`ifdef SHA1_CHAIN_EN
                  for (int i = 0; i < 5; i++) h[i] <= h_sum[i];
`else
                  // h stays at the initial constants: every block is independent
`endif
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.digest_o = digest_q;
   assign bus.done_o   = done_q;
   assign bus.panic_o  = panic_q;

endmodule
